scoreboard_registers: RTL

Parametrised integer register file for the core: configurable word width, register count and number of combinational read ports, with an optional same-cycle writeback bypass. Adds a per-register busy scoreboard that issue logic uses to reserve destinations of long-latency operations and to stall on read-after-write hazards. Sits between decode/issue (read and reserve ports) and writeback (write port); register 0 is hardwired to zero.

---
 rtl/scoreboard_registers.sv | 102 ++++++++++
 1 files changed

// File: rtl/scoreboard_registers.sv
// scoreboard_registers: integer register file with per-register busy scoreboard.
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   rs_addr/rs_data     : READ_PORTS combinational read ports (packed per port)
//   rs_busy, stall      : scoreboard bit per read port (after bypass), OR of them
//   rd/data/should_write: writeback port, clears the busy bit of rd
//   reserve_rd/reserve  : marks a destination pending for a long-latency producer
//   busy_count          : population count of the busy bits
// Register 0 always reads zero and is never busy.
module scoreboard_registers #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned READ_PORTS = 2,
  parameter int unsigned BYPASS     = 1,
  localparam int unsigned ADDR_W    = $clog2(REG_COUNT),
  localparam int unsigned CNT_W     = $clog2(REG_COUNT + 1)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [READ_PORTS*ADDR_W-1:0] rs_addr,
  output logic [READ_PORTS*XLEN-1:0]   rs_data,
  output logic [READ_PORTS-1:0]        rs_busy,
  input  logic [ADDR_W-1:0]            rd,
  input  logic [XLEN-1:0]              data,
  input  logic                         should_write,
  input  logic [ADDR_W-1:0]            reserve_rd,
  input  logic                         reserve,
  output logic                         stall,
  output logic [CNT_W-1:0]             busy_count
);

  logic [XLEN-1:0]      regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wr_en, rsv_en, cnt_inc, cnt_dec;

  assign wr_en  = should_write && (rd != '0);
  assign rsv_en = reserve && (reserve_rd != '0);

  // Scoreboard next state: a reserve on the same register as the write wins.
  always_comb begin
    busy_d  = busy_q;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (wr_en) begin
      busy_d[rd] = 1'b0;
    end
    if (rsv_en) begin
      busy_d[reserve_rd] = 1'b1;
    end
    // Count only real transitions so it tracks the busy population exactly.
    cnt_inc = rsv_en && !busy_q[reserve_rd];
    cnt_dec = wr_en && busy_q[rd] && !(rsv_en && (reserve_rd == rd));
    count_d = count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
  end

  // Scoreboard and count state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  // Register storage; entry 0 is never written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < int'(REG_COUNT); r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd] <= data;
    end
  end

  // Read ports with optional same-cycle writeback forwarding.
  always_comb begin
    logic [ADDR_W-1:0] a;
    rs_data = '0;
    rs_busy = '0;
    a       = '0;
    for (int i = 0; i < int'(READ_PORTS); i++) begin
      a = rs_addr[i*ADDR_W +: ADDR_W];
      if (a == '0) begin
        rs_data[i*XLEN +: XLEN] = '0;
        rs_busy[i]              = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (a == rd)) begin
        rs_data[i*XLEN +: XLEN] = data;
        rs_busy[i]              = 1'b0;
      end else begin
        rs_data[i*XLEN +: XLEN] = regs_q[a];
        rs_busy[i]              = busy_q[a];
      end
    end
  end

  assign stall      = |rs_busy;
  assign busy_count = count_q;

endmodule
